// File: rtl/seq_digit_comparator_pkg.sv
// Shared definitions for the digit-serial magnitude comparator.
// States are plain 2-bit constants so older tools can consume them unchanged.
package seq_digit_comparator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMP  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef struct packed {
    logic less;
    logic more;
    logic equal;
  } result_t;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seq_digit_comparator_digit_cmp.sv
// Combinational compare of one DIGIT-bit slice of both operands.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             gt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/seq_digit_comparator.sv
// Digit-serial MSB-first magnitude comparator with early termination.
// Signed mode flips both sign bits so the unsigned datapath gives signed order.
module seq_digit_comparator
  import seq_digit_comparator_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int DIGIT      = 4,
  localparam int NUM_DIGITS = WIDTH / DIGIT,
  localparam int CNT_W      = cnt_width(WIDTH / DIGIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             less_o,
  output logic             more_o,
  output logic             equal_o
);

  localparam logic [WIDTH-1:0] SIGN_MASK  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   xs_q, xs_d;
  logic [WIDTH-1:0]   ys_q, ys_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  result_t            res_q, res_d;
  logic [WIDTH-1:0]   flip;
  logic               dig_lt, dig_gt, dig_eq;

  digit_cmp #(
    .DIGIT(DIGIT)
  ) u_digit_cmp (
    .a_i (xs_q[WIDTH-1 -: DIGIT]),
    .b_i (ys_q[WIDTH-1 -: DIGIT]),
    .lt_o(dig_lt),
    .gt_o(dig_gt),
    .eq_o(dig_eq)
  );

  assign flip = signed_mode_i ? SIGN_MASK : '0;

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_i) begin
          state_d = ST_CMP;
          xs_d    = x_i ^ flip;
          ys_d    = y_i ^ flip;
          cnt_d   = '0;
        end
      end
      ST_CMP: begin
        if (!dig_eq) begin
          state_d = ST_DONE;
          res_d   = '{less: dig_lt, more: dig_gt, equal: 1'b0};
        end else if (cnt_q == LAST_DIGIT) begin
          state_d = ST_DONE;
          res_d   = '{less: 1'b0, more: 1'b0, equal: 1'b1};
        end else begin
          xs_d  = xs_q << DIGIT;
          ys_d  = ys_q << DIGIT;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy_o  = (state_q == ST_CMP);
  assign done_o  = (state_q == ST_DONE);
  assign less_o  = res_q.less;
  assign more_o  = res_q.more;
  assign equal_o = res_q.equal;

endmodule

// File: tb/tb_seq_digit_comparator.sv
// Bench for seq_digit_comparator: directed table at DIGIT=4 plus a random
// sweep over DIGIT in {1,2,4,8,16} against an arithmetic reference.
module tb_seq_digit_comparator;

  localparam int W    = 16;
  localparam int NI   = 5;
  localparam int MAIN = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sm = 1'b0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;

  logic busy_w  [NI];
  logic done_w  [NI];
  logic less_w  [NI];
  logic more_w  [NI];
  logic equal_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_digit_comparator #(
      .WIDTH(W),
      .DIGIT(1 << g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .signed_mode_i(sm),
      .x_i          (x),
      .y_i          (y),
      .busy_o       (busy_w[g]),
      .done_o       (done_w[g]),
      .less_o       (less_w[g]),
      .more_o       (more_w[g]),
      .equal_o      (equal_w[g])
    );
  end

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sm;
    logic         b2b;
    int           cyc;
    logic         el;
    logic         em;
    logic         ee;
    string        nm;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issue one operation on the DIGIT=4 instance and follow it to its done pulse.
  task automatic run_main(input vec_t v, input bit disturb);
    int nb = 0;
    int to = 0;
    x = v.x; y = v.y; sm = v.sm; start = 1'b1;
    step();
    start = 1'b0;
    chk({v.nm, "_busy_after_accept"}, busy_w[MAIN], 1);
    while (!done_w[MAIN] && to < 40) begin
      if (busy_w[MAIN]) nb++;
      if (disturb) begin
        x = 16'($urandom); y = 16'($urandom);
        sm = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      end
      step();
      to++;
    end
    start = 1'b0;
    chk({v.nm, "_done_seen"}, done_w[MAIN], 1);
    chk({v.nm, "_cmp_cycles"}, nb, v.cyc);
    chk({v.nm, "_busy_at_done"}, busy_w[MAIN], 0);
    chk({v.nm, "_less"}, less_w[MAIN], v.el);
    chk({v.nm, "_more"}, more_w[MAIN], v.em);
    chk({v.nm, "_equal"}, equal_w[MAIN], v.ee);
  endtask

  task automatic hold_check(input vec_t v);
    step();
    chk({v.nm, "_done_one_cycle"}, done_w[MAIN], 0);
    chk({v.nm, "_idle_busy"}, busy_w[MAIN], 0);
    chk({v.nm, "_hold_less"}, less_w[MAIN], v.el);
    chk({v.nm, "_hold_more"}, more_w[MAIN], v.em);
    chk({v.nm, "_hold_equal"}, equal_w[MAIN], v.ee);
  endtask

  // Reference: ordinary integer compare and first-differing-digit search.
  task automatic sweep(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [W-1:0]        xv, yv;
      logic                smv;
      logic signed [W-1:0] sx, sy;
      logic                el, em, ee;
      bit                  seen [NI];
      int                  nb   [NI];
      int                  lat  [NI];
      int                  to;
      bit                  all_seen;
      xv = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       yv = xv;
        1:       yv = xv ^ (16'(1) << $urandom_range(0, 15));
        default: yv = 16'($urandom);
      endcase
      smv = 1'($urandom_range(0, 1));
      sx = xv; sy = yv;
      if (smv) begin
        el = (sx < sy); em = (sx > sy);
      end else begin
        el = (xv < yv); em = (xv > yv);
      end
      ee = (xv == yv);
      for (int g = 0; g < NI; g++) begin
        int d, nd, mask;
        d = 1 << g; nd = W / d; mask = (1 << d) - 1;
        lat[g] = nd;
        for (int i = 0; i < nd; i++) begin
          int sh;
          sh = W - (i + 1) * d;
          if (((int'(xv) >> sh) & mask) != ((int'(yv) >> sh) & mask)) begin
            lat[g] = i + 1;
            break;
          end
        end
        seen[g] = 1'b0;
        nb[g]   = 0;
      end
      x = xv; y = yv; sm = smv; start = 1'b1;
      step();
      start = 1'b0;
      to = 0;
      all_seen = 1'b0;
      while (!all_seen && to < 40) begin
        all_seen = 1'b1;
        for (int g = 0; g < NI; g++) begin
          if (!seen[g]) begin
            if (done_w[g]) begin
              seen[g] = 1'b1;
              chk($sformatf("sweep_d%0d_latency", 1 << g), nb[g], lat[g]);
              chk($sformatf("sweep_d%0d_less", 1 << g), less_w[g], el);
              chk($sformatf("sweep_d%0d_more", 1 << g), more_w[g], em);
              chk($sformatf("sweep_d%0d_equal", 1 << g), equal_w[g], ee);
            end else begin
              if (busy_w[g]) nb[g]++;
              all_seen = 1'b0;
            end
          end
        end
        if (!all_seen) begin
          step();
          to++;
        end
      end
      for (int g = 0; g < NI; g++)
        if (!seen[g]) chk($sformatf("sweep_d%0d_timeout", 1 << g), 0, 1);
    end
  endtask

  vec_t tbl [7];

  initial begin
    bit saw_done;
    tbl[0] = '{16'd2,    16'd2,    1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, "eq_2_2"};
    tbl[1] = '{16'd22,   16'd444,  1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, "lt_22_444"};
    tbl[2] = '{16'd777,  16'd111,  1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, "gt_777_111"};
    tbl[3] = '{16'h8888, 16'h8888, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1, "b2b_eq_8888"};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, "signed_ffff_1"};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, "unsigned_ffff_1"};
    tbl[6] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, "b2b_signed_min_max"};

    rst = 1'b1;
    repeat (2) step();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset_d%0d_busy", 1 << g), busy_w[g], 0);
      chk($sformatf("reset_d%0d_done", 1 << g), done_w[g], 0);
      chk($sformatf("reset_d%0d_less", 1 << g), less_w[g], 0);
      chk($sformatf("reset_d%0d_more", 1 << g), more_w[g], 0);
      chk($sformatf("reset_d%0d_equal", 1 << g), equal_w[g], 0);
    end
    rst = 1'b0;
    step();
    chk("post_reset_idle_done", done_w[MAIN], 0);

    for (int i = 0; i < 7; i++) begin
      run_main(tbl[i], 1'b0);
      if (!(i + 1 < 7 && tbl[i + 1].b2b)) hold_check(tbl[i]);
    end

    // Inputs toggled throughout CMP must not disturb the captured operands.
    run_main('{16'h1234, 16'h1235, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, "ignore_inputs_in_cmp"}, 1'b1);
    hold_check('{16'h1234, 16'h1235, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, "ignore_inputs_in_cmp"});

    // Abort in the second CMP cycle: outputs clear, no done pulse follows.
    x = 16'h1234; y = 16'h1235; sm = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("abort_busy_before_rst", busy_w[MAIN], 1);
    rst = 1'b1;
    step();
    chk("abort_busy", busy_w[MAIN], 0);
    chk("abort_done", done_w[MAIN], 0);
    chk("abort_less", less_w[MAIN], 0);
    chk("abort_more", more_w[MAIN], 0);
    chk("abort_equal", equal_w[MAIN], 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      step();
      if (done_w[MAIN] || busy_w[MAIN]) saw_done = 1'b1;
    end
    chk("abort_no_done_after", saw_done, 0);

    sweep(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_digit_comparator.md
Name: seq_digit_comparator

Overview:
- Parametrised, digit-serial magnitude comparator for two WIDTH-bit operands, evaluated MSB-first at DIGIT bits per cycle.
- Terminates early at the first differing digit.
- Supports unsigned and two's-complement modes, selected per operation.
- Sits beside the combinational N-bit comparator where area matters more than latency. Uses a start/done handshake and holds its results until the next start.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits compared per cycle; must satisfy 1 <= DIGIT <= WIDTH.
NUM_DIGITS, WIDTH/DIGIT, derived; not to be overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a comparison; sampled only when busy=0.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
x  input  WIDTH  operand X; captured with start.
y  input  WIDTH  operand Y; captured with start.
busy  output  1  high while the state is CMP.
done  output  1  one-cycle pulse when the result registers update.
less  output  1  X < Y for the last completed operation.
more  output  1  X > Y for the last completed operation.
equal  output  1  X == Y for the last completed operation.

Behaviour:
- Reset:
  - When rst=1 at an edge, state goes to IDLE.
  - busy, done, less, more and equal all go to 0; the shift registers clear.
  - rst has priority over every other input, including during CMP (an aborted operation produces no done).
- States:
  - IDLE: busy=0, done=0.
  - CMP: busy=1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE or DONE with start=1 goes to CMP.
  - DONE with start=0 goes to IDLE.
  - CMP goes to DONE when decided.
  - start while in CMP is ignored and has no effect on the captured operands.
- Capture:
  - On the accepting edge, load x and y into WIDTH-bit shift registers and load the digit counter with 0.
  - If signed_mode=1, invert bit WIDTH-1 of both captured operands. An unsigned compare then yields the signed ordering.
  - less, more and equal keep their previous values until the operation completes.
- CMP cycle:
  - Compare the top DIGIT bits of both shift registers.
  - If they differ: register less/more accordingly, set equal=0, and go to DONE.
  - If they are equal and the counter = NUM_DIGITS-1: set equal=1, set less=more=0, and go to DONE.
  - Otherwise: shift both registers left by DIGIT and increment the counter.
- Latency:
  - Let k be the index of the first differing digit, counting the MSB digit as 0.
  - done is high in the cycle k+2 after the accepting edge, i.e. k+1 CMP cycles.
  - For equal operands, NUM_DIGITS CMP cycles.
  - Back-to-back: start asserted during DONE is accepted, so the next CMP begins with no idle cycle.
- Invariants:
  - After the first completion, exactly one of less/more/equal is 1; all three are 0 only after reset.
  - done=1 implies busy=0.
- Degenerate DIGIT=WIDTH: a single CMP cycle for every operation.

Decomposition:
- Shared package: state enum (IDLE, CMP, DONE) and a localparam function computing the counter width, $clog2(NUM_DIGITS) with a minimum of 1.
- Sub-module digit_cmp: combinational DIGIT-bit compare producing lt/gt/eq; one instance, in the CMP datapath.
- FSM, shift registers and result registers stay in the top module.

Test Plan:
- WIDTH=16, DIGIT=4, unsigned, x=2, y=2 -> equal=1, less=more=0; done 4 CMP cycles after accept; busy high for exactly those 4 cycles.
- x=22 (0x0016), y=444 (0x01BC), unsigned -> less=1; digit 1 differs, so done after 2 CMP cycles.
- x=777 (0x0309), y=111 (0x006F) -> more=1 after 2 CMP cycles. Then back-to-back start in the DONE cycle with x=y=0x8888 -> equal=1 after 4 more CMP cycles, with no IDLE cycle in between.
- x=0xFFFF, y=0x0001:
  - signed_mode=1 -> less=1 after 1 CMP cycle.
  - signed_mode=0 -> more=1 after 1 CMP cycle.
- During CMP for x=0x1234, y=0x1235: toggle x/y/start -> ignored, result less=1 after 4 CMP cycles. Repeat with rst=1 asserted in the 2nd CMP cycle -> next edge: state IDLE, all outputs 0, no done pulse.
- Parameter sweep, DIGIT in {1,2,4,8,16} at WIDTH=16: randomised x, y and signed_mode checked against a reference signed/unsigned compare. Check result correctness and latency = (first differing digit index + 1), or NUM_DIGITS for equal operands.
